// File: rtl/display_pkg.sv
// Shared constants for the BCD display: segment codes (g..a, active-low),
// conversion FSM encoding and a 10^n helper for the saturation limits.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: start loads the binary word, then one add-3/shift
// step per cycle for DATA_W cycles; done pulses the cycle the BCD result is valid.
module bin2bcd_seq #(
  parameter int DATA_W   = 32,
  parameter int N_DIGITS = 4
) (
  input  logic                     fast_clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [DATA_W-1:0]        bin_i,
  output logic [N_DIGITS-1:0][3:0] bcd_o,
  output logic                     done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]        bin_q, bin_d;
  logic [N_DIGITS-1:0][3:0] bcd_q, bcd_d, adj;
  logic [N_DIGITS*4:0]      shifted;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;

  // Input is pre-clamped below 10^N_DIGITS, so every prefix fits in N_DIGITS digits.
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++)
      adj[k] = (bcd_q[k] >= 4'd5) ? bcd_q[k] + 4'd3 : bcd_q[k];
    shifted = {adj, bin_q[DATA_W-1]};
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      bcd_d  = shifted[N_DIGITS*4-1:0];
      bin_d  = {bin_q[DATA_W-2:0], 1'b0};
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/display_bcd_scan.sv
// Multiplexed 7-segment driver: load captures a value, converts it to BCD in the
// background, commits it atomically to the display buffer, which is scanned digit by digit.
module display_bcd_scan
  import display_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int REFRESH_RATE_HZ = 800,
  parameter int N_DIGITS        = 4,
  parameter int DATA_W          = 32,
  parameter bit SIGNED_MODE     = 1'b0,
  parameter bit BLANK_LEADING   = 1'b1
) (
  input  logic                fast_clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_W-1:0]   valor_in,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          seg_out,
  output logic [N_DIGITS-1:0] anode_sel
);

  localparam int COUNTER_MAX = CLK_FREQ / REFRESH_RATE_HZ;
  localparam int CNT_MAX_C   = (COUNTER_MAX < 1) ? 1 : COUNTER_MAX;
  localparam int CNT_W       = (CNT_MAX_C > 1) ? $clog2(CNT_MAX_C) : 1;
  localparam int SEL_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [63:0] LIM_POS = pow10(N_DIGITS) - 64'd1;
  localparam logic [63:0] LIM_NEG = pow10(N_DIGITS - 1) - 64'd1;

  state_e state_q, state_d;
  logic   start, commit, done;

  logic                     in_neg, in_sat;
  logic [DATA_W-1:0]        in_mag, clamp;
  logic [63:0]              lim;
  logic [N_DIGITS-1:0][3:0] bcd, buf_q;
  logic                     neg_pend_q, sat_pend_q, buf_neg_q, overflow_q;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d, msd, place;
  logic [SEL_W:0]      minus_place;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  // Sign/magnitude and clamp are resolved at load time so the converter sees a fitting value.
  always_comb begin
    in_neg = SIGNED_MODE && valor_in[DATA_W-1];
    in_mag = in_neg ? (~valor_in + DATA_W'(1)) : valor_in;
    lim    = in_neg ? LIM_NEG : LIM_POS;
    in_sat = 64'(in_mag) > lim;
    clamp  = in_sat ? DATA_W'(lim) : in_mag;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    start  = (state_q == IDLE) && load;
    commit = (state_q == COMMIT);
  end

  bin2bcd_seq #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_b2b (
    .fast_clk (fast_clk),
    .rst      (rst),
    .start_i  (start),
    .bin_i    (clamp),
    .bcd_o    (bcd),
    .done_o   (done)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_W'(CNT_MAX_C - 1)) begin
      cnt_d = '0;
      sel_d = (sel_q == SEL_W'(N_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  // Selector 0 is the leftmost digit, i.e. the highest BCD place.
  always_comb begin
    msd = '0;
    for (int k = 0; k < N_DIGITS; k++)
      if (buf_q[k] != 4'd0) msd = SEL_W'(k);
    place       = SEL_W'(N_DIGITS - 1) - sel_q;
    minus_place = BLANK_LEADING ? {1'b0, msd} + (SEL_W+1)'(1) : (SEL_W+1)'(N_DIGITS - 1);
    if (buf_neg_q && ({1'b0, place} == minus_place)) seg_d = SEG_MINUS;
    else if (BLANK_LEADING && (place > msd))         seg_d = SEG_BLANK;
    else                                             seg_d = seg_decode(buf_q[place]);
    an_d = ~(N_DIGITS'(1) << sel_q);
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      neg_pend_q <= 1'b0;
      sat_pend_q <= 1'b0;
      buf_q      <= '0;
      buf_neg_q  <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      sel_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      if (start) begin
        neg_pend_q <= in_neg;
        sat_pend_q <= in_sat;
      end
      if (commit) begin
        buf_q      <= bcd;
        buf_neg_q  <= neg_pend_q;
        overflow_q <= sat_pend_q;
      end
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign overflow  = overflow_q;
  assign seg_out   = seg_q;
  assign anode_sel = an_q;

endmodule

// File: tb/tb_display_bcd_scan.sv
// Scoreboarded bench: an unsigned and a signed instance; expected displays come from
// a decimal-arithmetic model and are checked by monitors when busy falls.
module tb_display_bcd_scan;

  localparam int DW = 16;

  typedef struct packed {
    logic [3:0][6:0] seg;  // index 0 = leftmost digit
    logic            ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld0 = 1'b0, ld1 = 1'b0;
  logic [DW-1:0] v0 = '0, v1 = '0;
  logic busy0, busy1, ov0, ov1;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;

  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  display_bcd_scan #(.CLK_FREQ(8000), .REFRESH_RATE_HZ(800), .N_DIGITS(4), .DATA_W(DW),
                     .SIGNED_MODE(1'b0), .BLANK_LEADING(1'b1)) dut0 (
    .fast_clk(clk), .rst(rst), .load(ld0), .valor_in(v0),
    .busy(busy0), .overflow(ov0), .seg_out(seg0), .anode_sel(an0));

  display_bcd_scan #(.CLK_FREQ(8000), .REFRESH_RATE_HZ(800), .N_DIGITS(4), .DATA_W(DW),
                     .SIGNED_MODE(1'b1), .BLANK_LEADING(1'b1)) dut1 (
    .fast_clk(clk), .rst(rst), .load(ld1), .valor_in(v1),
    .busy(busy1), .overflow(ov1), .seg_out(seg1), .anode_sel(an1));

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  // Reference: decimal digits of the clamped magnitude, blanking and sign placement.
  function automatic exp_t model(input logic [DW-1:0] v, input bit sgn);
    exp_t e;
    int unsigned m;
    int lim, fz;
    int d[4];
    int pw[4] = '{1000, 100, 10, 1};
    bit neg;
    neg = sgn && v[DW-1];
    m   = neg ? (32'd65536 - {16'd0, v}) : {16'd0, v};
    lim = neg ? 999 : 9999;
    e.ov = (m > lim);
    if (m > lim) m = lim;
    fz = 3;
    for (int k = 3; k >= 0; k--) begin
      d[k] = (m / pw[k]) % 10;
      if (d[k] != 0) fz = k;
    end
    for (int k = 0; k < 4; k++) e.seg[k] = (k < fz) ? 7'b1111111 : seg_of(d[k]);
    if (neg && fz > 0) e.seg[fz-1] = 7'b0111111;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic capture(input int id, output logic [3:0][6:0] segs);
    logic [3:0] an;
    logic [6:0] sg;
    segs = 'x;
    repeat (41) begin
      @(negedge clk);
      an = (id == 0) ? an0 : an1;
      sg = (id == 0) ? seg0 : seg1;
      for (int k = 0; k < 4; k++)
        if (an == ~(4'b0001 << k)) segs[k] = sg;
    end
  endtask

  task automatic check_display(input int id, input string tag, input exp_t e);
    logic [3:0][6:0] segs;
    capture(id, segs);
    for (int k = 0; k < 4; k++)
      chk($sformatf("dut%0d_%s_digit%0d", id, tag, k), 32'(segs[k]), 32'(e.seg[k]));
  endtask

  task automatic monitor(input int id);
    logic pb, b;
    exp_t e;
    int qs;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      b = (id == 0) ? busy0 : busy1;
      if (rst) pb = 1'b0;
      else begin
        if (pb && !b) begin
          qs = (id == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_commit got=commit exp=none", id);
          end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("dut%0d_overflow", id), 32'((id == 0) ? ov0 : ov1), 32'(e.ov));
            check_display(id, "commit", e);
          end
          b = (id == 0) ? busy0 : busy1;
        end
        pb = b;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic load_val(input int id, input logic [DW-1:0] v, input bit accept);
    @(posedge clk); #1;
    if (id == 0) begin ld0 = 1'b1; v0 = v; if (accept) q0.push_back(model(v, 1'b0)); end
    else         begin ld1 = 1'b1; v1 = v; if (accept) q1.push_back(model(v, 1'b1)); end
    @(posedge clk); #1;
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  // Load at cycle 0: busy high in cycles 1..DW+2, low from DW+3, then drain scoreboard.
  task automatic run_load(input int id, input logic [DW-1:0] v);
    int qs;
    load_val(id, v, 1'b1);
    @(negedge clk);
    chk($sformatf("dut%0d_busy_c1", id), 32'((id == 0) ? busy0 : busy1), 32'd1);
    repeat (DW + 1) @(negedge clk);
    chk($sformatf("dut%0d_busy_c%0d", id, DW + 2), 32'((id == 0) ? busy0 : busy1), 32'd1);
    @(negedge clk);
    chk($sformatf("dut%0d_busy_c%0d", id, DW + 3), 32'((id == 0) ? busy0 : busy1), 32'd0);
    repeat (60) @(negedge clk);
    qs = (id == 0) ? q0.size() : q1.size();
    chk($sformatf("dut%0d_commit_drained", id), 32'(qs), 32'd0);
  endtask

  task automatic scan_check();
    logic [3:0] prev;
    int run;
    bit first;
    @(negedge clk);
    prev = an0; run = 1; first = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (an0 == prev) run++;
      else begin
        chk("scan_order", 32'(an0), 32'({prev[2:0], prev[3]}));
        if (!first) chk("scan_dwell", 32'(run), 32'd10);
        first = 1'b0; run = 1; prev = an0;
      end
    end
  endtask

  initial begin
    bit saw;
    exp_t z;
    z = model('0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy0", 32'(busy0), 32'd0);  chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_seg0", 32'(seg0), 32'h7f);   chk("rst_an0", 32'(an0), 32'hf);
    chk("rst_busy1", 32'(busy1), 32'd0);  chk("rst_seg1", 32'(seg1), 32'h7f);
    @(posedge clk); #1 rst = 1'b0;
    check_display(0, "post_reset", z);

    run_load(0, 16'd1234);
    scan_check();
    run_load(0, 16'd42);
    run_load(0, 16'd12345);
    run_load(0, 16'd7);
    run_load(0, 16'd50000);
    chk("ov_before_abort", 32'(ov0), 32'd1);

    // Reset in the middle of a conversion: outputs drop at once, nothing commits.
    load_val(0, 16'd4321, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    void'(q0.pop_back());
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);  chk("abort_ov", 32'(ov0), 32'd0);
    chk("abort_seg", 32'(seg0), 32'h7f);   chk("abort_an", 32'(an0), 32'hf);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_display(0, "after_abort", z);
    chk("abort_busy_after", 32'(busy0), 32'd0);

    // Second load at cycle 5 must be dropped, not queued or restarted.
    load_val(0, 16'd1111, 1'b1);
    repeat (4) @(posedge clk);
    #1 begin ld0 = 1'b1; v0 = 16'd2222; end
    @(posedge clk); #1 ld0 = 1'b0;
    repeat (14) @(negedge clk);
    chk("ignored_busy_end", 32'(busy0), 32'd0);
    saw = 1'b0;
    repeat (60) begin @(negedge clk); if (busy0) saw = 1'b1; end
    chk("ignored_no_rerun", 32'(saw), 32'd0);
    chk("ignored_drained", 32'(q0.size()), 32'd0);

    repeat (6) run_load(0, DW'($urandom_range(0, 65535)));

    run_load(1, 16'hFFFB);
    run_load(1, 16'h8000);
    run_load(1, 16'd987);
    repeat (6) run_load(1, DW'($urandom_range(0, 65535)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
